// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------
// Round-robin, burst-locking arbiter for the single write port of the async
// FIFO. NREQ requesters in the write clock domain each present a
// valid/ready/last stream. One owner is granted at a time and keeps the grant
// until it sends a beat with last set or has sent MAXBURST beats. Priority then
// rotates to the requester after the one just served.
//
// Handshake: a beat moves on requester i in a cycle where
// req_valid[i] & req_ready[i] is high at the rising edge of wclk. req_ready is
// one-hot or zero, never depends on req_valid, and is only given to the current
// owner while the FIFO is not full. winc is high exactly in those cycles, so
// every accepted beat is written to the FIFO once.
//
// Ports:
//   wclk       write-domain clock, all logic on the rising edge
//   wrst       synchronous active-high reset
//   req_valid  per-requester data valid
//   req_last   per-requester last beat of a burst (used only with valid)
//   req_wdata  flattened data, requester i at [i*DSIZE +: DSIZE]
//   req_ready  per-requester accept, one-hot or zero
//   wfull      FIFO full flag (backpressure)
//   winc       FIFO write strobe
//   wdata      FIFO write data (owner's data while busy, else 0)
//   owner      index of the current owner, meaningful while busy
//   busy       high while a burst is granted; this is the FSM state bit
module fifo_wr_arbiter #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8,
  localparam int OW      = $clog2(NREQ),
  localparam int CW      = $clog2(MAXBURST + 1)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [OW-1:0]   last_owner;
  logic [CW-1:0]   beat_cnt;

  logic [OW-1:0]   next_owner;
  logic            found;
  int              idx;
  logic            own_valid;
  logic            own_last;
  logic [DSIZE-1:0] own_data;
  logic            xfer;
  logic            release_now;

  // Rotating search: first valid requester starting at last_owner+1, wrapping.
  always_comb begin
    next_owner = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (!found && req_valid[idx[OW-1:0]]) begin
        found      = 1'b1;
        next_owner = idx[OW-1:0];
      end
    end
  end

  // Owner's stream, selected with constant indices.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_wdata[i*DSIZE +: DSIZE];
      end
    end
  end

  assign busy = (state == BURST);

  // Reset gates the write side in the same cycle so an abandoned burst
  // cannot sneak one last beat into the FIFO.
  assign xfer        = busy & own_valid & ~wfull & ~wrst;
  assign release_now = xfer & (own_last | (beat_cnt == CW'(MAXBURST - 1)));
  assign winc        = xfer;

  always_comb begin
    req_ready = '0;
    if (busy && !wrst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner == OW'(i)) begin
          req_ready[i] = ~wfull;
        end
      end
    end
  end

  assign wdata = (busy && !wrst) ? own_data : '0;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= IDLE;
      owner      <= '0;
      beat_cnt   <= '0;
      last_owner <= OW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner    <= next_owner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            if (release_now) begin
              // last and the MAXBURST-th beat together give one release
              state      <= IDLE;
              last_owner <= owner;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter with NREQ=4 and a small MAXBURST=4 so the burst
// cap is reached quickly. Requester sources are queues of (data, last) beats;
// a spec-level reference model predicts grants and outputs every cycle, and a
// per-requester scoreboard checks that each pushed beat is written exactly
// once and in order.
module tb_fifo_wr_arbiter;
  localparam int DSIZE    = 8;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 4;
  localparam int OW       = $clog2(NREQ);

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ*DSIZE-1:0] req_wdata = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull = 1'b0;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [OW-1:0]         owner;
  logic                  busy;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_last(req_last),
    .req_wdata(req_wdata), .req_ready(req_ready), .wfull(wfull),
    .winc(winc), .wdata(wdata), .owner(owner), .busy(busy)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 wclk = ~wclk;

  int cycle = 0;
  always @(posedge wclk) cycle++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- requester sources ----------------
  logic [DSIZE-1:0] src_d  [NREQ][$];
  logic             src_l  [NREQ][$];
  logic [DSIZE-1:0] sent_q [NREQ][$];
  logic [NREQ-1:0]  valid_en = '1;
  logic [NREQ-1:0]  hs = '0;

  // Pops accepted beats and presents the next head, 2 time units after the edge.
  always @(posedge wclk) begin
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && src_d[i].size() > 0) begin
        void'(src_d[i].pop_front());
        void'(src_l[i].pop_front());
      end
      req_valid[i] = valid_en[i] && (src_d[i].size() > 0);
      req_last[i]  = (src_d[i].size() > 0) ? src_l[i][0] : 1'b0;
      req_wdata[i*DSIZE +: DSIZE] = (src_d[i].size() > 0) ? src_d[i][0] : '0;
    end
  end

  task automatic push(input int r, input logic [DSIZE-1:0] d, input logic l);
    src_d[r].push_back(d);
    src_l[r].push_back(l);
    sent_q[r].push_back(d);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (src_d[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int cyc; int who; logic [DSIZE-1:0] d; } wr_t;
  wr_t wr_log[$];

  int m_busy  = 0;
  int m_owner = 0;
  int m_beats = 0;
  int m_last  = NREQ - 1;

  always @(negedge wclk) begin
    logic [DSIZE-1:0] e;
    int pick;
    hs = req_valid & req_ready;
    if (cycle >= 1) begin
      chk("never_winc_when_full", 32'(winc & wfull), 32'd0);
      if (winc === 1'b1) begin
        wr_log.push_back('{cycle, int'(owner), wdata});
        if (sent_q[owner].size() > 0) e = sent_q[owner].pop_front();
        else e = ~wdata;
        chk("sb_write_data", 32'(wdata), 32'(e));
      end
      if (wrst) begin
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        m_busy = 0;
        m_last = NREQ - 1;
      end else if (m_busy == 0) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd0);
        chk("idle_winc", 32'(winc), 32'd0);
        chk("idle_wdata", 32'(wdata), 32'd0);
        pick = -1;
        for (int k = 1; k <= NREQ; k++)
          if (pick < 0 && req_valid[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
        if (pick >= 0) begin
          m_busy  = 1;
          m_owner = pick;
          m_beats = 0;
        end
      end else begin
        chk("burst_busy", 32'(busy), 32'd1);
        chk("burst_owner", 32'(owner), 32'(m_owner));
        chk("burst_ready", 32'(req_ready), wfull ? 32'd0 : (32'd1 << m_owner));
        chk("burst_winc", 32'(winc), 32'(req_valid[m_owner] & ~wfull));
        chk("burst_wdata", 32'(wdata), 32'(req_wdata[m_owner*DSIZE +: DSIZE]));
        if (req_valid[m_owner] && !wfull) begin
          m_beats++;
          if (req_last[m_owner] || m_beats == MAXBURST) begin
            m_busy = 0;
            m_last = m_owner;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    tick(1);
    @(negedge wclk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_winc", 32'(winc), 32'd0);
    tick(1);
    wrst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_drained"}, 32'(pending()), 32'd0);
    tick(2);
  endtask

  // Expected writes: data, owner, cycle offset from the test's start cycle.
  logic [DSIZE-1:0] exp_q[$];
  int exp_who[$];
  int exp_cyc[$];
  int t0;

  task automatic expect_wr(input logic [DSIZE-1:0] d, input int who, input int off);
    exp_q.push_back(d);
    exp_who.push_back(who);
    exp_cyc.push_back(off);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(wr_log[i].d), 32'(exp_q[i]));
      chk($sformatf("%s_who%0d", tag, i), 32'(wr_log[i].who), 32'(exp_who[i]));
      chk($sformatf("%s_cyc%0d", tag, i), 32'(wr_log[i].cyc - t0), 32'(exp_cyc[i]));
    end
    exp_q.delete();
    exp_who.delete();
    exp_cyc.delete();
  endtask

  task automatic rand_phase(input int ncyc);
    int r;
    int len;
    for (int c = 0; c < ncyc; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r   = $urandom_range(0, NREQ - 1);
        len = $urandom_range(1, 6);
        if (src_d[r].size() < 12)
          for (int b = 0; b < len; b++)
            push(r, DSIZE'($urandom_range(0, 255)), (b == len - 1));
      end
      for (int i = 0; i < NREQ; i++) valid_en[i] = ($urandom_range(0, 99) < 85);
      wfull = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    valid_en = '1;
    wfull    = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset();

    // single burst from requester 2
    wr_log.delete();
    t0 = cycle;
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    drain("single", 50);
    @(negedge wclk);
    chk("single_busy_after", 32'(busy), 32'd0);
    expect_wr(8'hA1, 2, 1); expect_wr(8'hA2, 2, 2); expect_wr(8'hA3, 2, 3);
    check_log("single");

    // round robin among 0,1,3 with one-beat bursts
    do_reset();
    wr_log.delete();
    t0 = cycle;
    push(0, 8'hB0, 1'b1); push(0, 8'hB3, 1'b1);
    push(1, 8'hB1, 1'b1); push(1, 8'hB4, 1'b1);
    push(3, 8'hB2, 1'b1); push(3, 8'hB5, 1'b1);
    drain("rr", 60);
    expect_wr(8'hB0, 0, 1); expect_wr(8'hB1, 1, 3); expect_wr(8'hB2, 3, 5);
    expect_wr(8'hB3, 0, 7); expect_wr(8'hB4, 1, 9); expect_wr(8'hB5, 3, 11);
    check_log("rr");

    // MAXBURST cap: req 1 streams 10 beats without last, req 0 competes
    do_reset();
    wr_log.delete();
    t0 = cycle;
    for (int b = 0; b < 10; b++) push(1, DSIZE'(8'h50 + b), 1'b0);
    tick(1);
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b1);
    drain("cap", 80);
    for (int b = 0; b < 4; b++) expect_wr(DSIZE'(8'h50 + b), 1, 1 + b);
    expect_wr(8'hC0, 0, 6); expect_wr(8'hC1, 0, 7);
    for (int b = 4; b < 8; b++) expect_wr(DSIZE'(8'h50 + b), 1, 5 + b);
    expect_wr(8'h58, 1, 14); expect_wr(8'h59, 1, 15);
    check_log("cap");

    // backpressure for 3 cycles starting at beat 2
    do_reset();
    wr_log.delete();
    t0 = cycle;
    push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
    tick(3);
    wfull = 1'b1;
    tick(1);
    @(negedge wclk);
    chk("bp_winc", 32'(winc), 32'd0);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    tick(2);
    wfull = 1'b0;
    drain("bp", 50);
    expect_wr(8'h10, 1, 1); expect_wr(8'h11, 1, 2);
    expect_wr(8'h12, 1, 6); expect_wr(8'h13, 1, 7);
    check_log("bp");

    // owner bubble, then reset mid-burst
    do_reset();
    wr_log.delete();
    t0 = cycle;
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
    tick(2);
    valid_en[3] = 1'b0;
    @(negedge wclk);
    chk("bub_busy", 32'(busy), 32'd1);
    chk("bub_owner", 32'(owner), 32'd3);
    chk("bub_winc", 32'(winc), 32'd0);
    tick(2);
    chk("bub_no_write", 32'(wr_log.size()), 32'd1);
    valid_en[3] = 1'b1;
    wrst = 1'b1;
    push(0, 8'h01, 1'b1);
    tick(1);
    wrst = 1'b0;
    @(negedge wclk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    drain("bub", 50);
    expect_wr(8'h30, 3, 1); expect_wr(8'h01, 0, 6);
    expect_wr(8'h31, 3, 8); expect_wr(8'h32, 3, 9);
    check_log("bub");

    // randomized traffic checked by the model and scoreboard
    do_reset();
    rand_phase(400);
    drain("rand", 3000);
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("rand_all_written%0d", i), 32'(sent_q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-locking arbiter that shares the single write port of the async FIFO (wdata/winc/wfull) among NREQ requesters in the write clock domain.
- Each requester presents a valid/ready/last stream. The arbiter grants one owner at a time and holds the grant until that owner's last beat or MAXBURST beats, whichever comes first. It then rotates priority.
- Sits directly in front of the FIFO write side. Its winc/wdata drive the FIFO, and the FIFO's wfull feeds back as backpressure.

Parameters:
DSIZE, 8, data word width; must match the FIFO DSIZE
NREQ, 4, number of requesters (2..16)
MAXBURST, 8, maximum beats per grant before forced release (>=1)

Ports:
wclk  input  1  write-domain clock; all logic on posedge
wrst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester data valid
req_last  input  NREQ  per-requester last beat of burst; sampled only with valid
req_wdata  input  NREQ*DSIZE  flattened data; requester i at [i*DSIZE +: DSIZE]
req_ready  output  NREQ  per-requester accept, one-hot or zero
wfull  input  1  FIFO full flag
winc  output  1  FIFO write strobe
wdata  output  DSIZE  FIFO write data
owner  output  clog2(NREQ)  index of current owner; valid when busy
busy  output  1  high in BURST state

Behaviour:
- Reset: wrst is sampled on posedge wclk.
  - Sets state=IDLE, busy=0, owner=0, beat count=0.
  - Sets the last-owner pointer to NREQ-1, so requester 0 has top priority after reset.
  - Outputs during reset: req_ready=0, winc=0, wdata=0.
  - Reset asserted mid-burst abandons the burst at once. No write occurs in that cycle.
- State IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward from last_owner+1, mod NREQ.
  - Register that index into owner, clear the beat count, and move to BURST on the next edge.
  - No transfer happens in IDLE, so every grant costs 1 bubble cycle.
  - If no req_valid bit is set, stay in IDLE.
- State BURST:
  - req_ready[owner] = ~wfull. All other req_ready bits = 0.
  - winc = req_valid[owner] & ~wfull, combinational.
  - wdata = req_wdata slice of owner whenever busy, else 0.
  - A transfer is valid&ready on the owner in a cycle. Each transfer increments the beat count.
  - Release occurs on a transfer with req_last[owner]=1, or on the transfer that brings the beat count to MAXBURST.
  - On release: last_owner <= owner, state <= IDLE.
- Owner valid low in BURST: hold the grant indefinitely. No timeout, no write. The beat count is unchanged.
- wfull high in BURST: ready=0, winc=0, grant held, no beat counted. The same data must be accepted once wfull drops.
- Never assert winc while wfull=1. This holds even though the FIFO also gates writes internally.
- Beat counter width is clog2(MAXBURST+1). It never wraps, because release happens at MAXBURST.
- Requests from non-owners arriving in BURST wait. They are considered at the next IDLE cycle.
- Fairness: any continuously valid requester is granted within NREQ-1 other grants.
- Pointer wrap: after owner NREQ-1, the search starts at 0.
- Single requester: back-to-back grants to the same requester are allowed, with a 1-cycle IDLE gap each time.
- req_last together with the MAXBURST-th beat causes a single release. Nothing carries over.

Test Plan:
- Reset then single burst: NREQ=4, MAXBURST=8. Req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on the third.
  - Required: IDLE 1 cycle, then winc on 3 consecutive cycles carrying those values, owner=2, then busy=0.
- Round-robin: reqs 0,1,3 all valid with 1-beat bursts (last=1) held continuously.
  - Required: grant order 0,1,3,0,1,3. Each winc is separated by exactly 1 idle cycle.
- MAXBURST cap: MAXBURST=4. Req 1 streams 10 beats with no last; req 0 is also valid.
  - Required: req 1 gets 4 beats, then req 0 is granted, then req 1 resumes at beat 5.
- Backpressure: wfull raised for 3 cycles mid-burst at beat 2 of 0x10..0x13.
  - Required: winc=0 and req_ready=0 for those 3 cycles. The beat count holds, and 0x12 is written once wfull drops.
  - Also check that the sequence is written exactly once with no duplicates.
- Owner bubble plus reset mid-burst: owner req 3 drops valid for 2 cycles, then wrst is pulsed for 1 cycle.
  - Required: grant is held with no winc during the gap.
  - After reset: busy=0, and req 0 wins the next arbitration over req 3 when both are valid.
